dmem_ctrl: RTL

Sequences every load/store from the pipeline MEM stage onto the 32-word, word-wide data memory.
- The memory port is a single rw_enable line (1 = write, 0 = read); a read result is registered and valid on the cycle after the address is presented.
- The controller performs RV32I byte/halfword/word access: lane extraction with sign/zero extension for loads, and read-modify-write for SB/SH.
- Misaligned and illegal accesses are flagged without touching memory.
- Req/resp valid-ready handshakes toward the pipeline hazard unit, which stalls MEM while req_ready or resp_valid is pending.

---
 rtl/dmem_pkg.sv | 28 ++
 rtl/dmem_ctrl_if.sv | 34 +++
 rtl/dmem_lane.sv | 45 ++++
 rtl/dmem_ctrl.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory controller.
package dmem_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_RDATA = 3'd2,
    ST_WRITE = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Unsigned variants only make sense for loads.
  function automatic logic f3_illegal(input logic [2:0] f3, input logic we);
    logic known;
    known = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
            (f3 == F3_BU) || (f3 == F3_HU);
    return !known || (we && f3[2]);
  endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// Pipeline request/response and data-memory port bundle for dmem_ctrl.
interface dmem_ctrl_if #(
  parameter int ADDR_W = 5
);
  import dmem_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;

  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  logic              mem_rw_enable;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_wr_data;
  logic [DATA_W-1:0] mem_re_data;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, mem_re_data,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_rw_enable, mem_address, mem_wr_data
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, mem_re_data,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_rw_enable, mem_address, mem_wr_data
  );

endinterface

// File: rtl/dmem_lane.sv
// Byte/halfword lane logic: load extraction with extension, store merge, alignment check.
module dmem_lane
  import dmem_pkg::*;
(
  input  logic [DATA_W-1:0] word_i,
  input  logic [2:0]        funct3_i,
  input  logic [1:0]        addr_i,
  input  logic [DATA_W-1:0] sdata_i,
  output logic [DATA_W-1:0] load_o,
  output logic [DATA_W-1:0] merged_o,
  output logic              misalign_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign byte_v = word_i[{addr_i, 3'b000} +: 8];
  assign half_v = addr_i[1] ? word_i[31:16] : word_i[15:0];

  always_comb begin
    load_o     = word_i;
    merged_o   = word_i;
    misalign_o = 1'b0;
    unique case (funct3_i)
      F3_B:    load_o = {{24{byte_v[7]}}, byte_v};
      F3_BU:   load_o = {24'd0, byte_v};
      F3_H:    load_o = {{16{half_v[15]}}, half_v};
      F3_HU:   load_o = {16'd0, half_v};
      default: load_o = word_i;
    endcase
    unique case (funct3_i[1:0])
      2'b00: merged_o[{addr_i, 3'b000} +: 8] = sdata_i[7:0];
      2'b01: begin
        merged_o[{addr_i[1], 4'b0000} +: 16] = sdata_i[15:0];
        misalign_o                           = addr_i[0];
      end
      2'b10: begin
        merged_o   = sdata_i;
        misalign_o = (addr_i != 2'b00);
      end
      default: merged_o = word_i;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// MEM-stage load/store sequencer for a 32-word single-port data memory.
// Optional macro DMEM_CTRL_RANGE_CHECK_EN flags addresses beyond the memory instead of aliasing.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  dmem_ctrl_if.slave   bus
);

  state_e              state_q, state_d;
  logic [ADDR_W+1:0]   addr_q, addr_d;
  logic [2:0]          f3_q, f3_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   wr_q, wr_d;
  logic                resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
  logic                resp_err_q, resp_err_d;

  logic                idle;
  logic [2:0]          lane_f3;
  logic [1:0]          lane_addr;
  logic [DATA_W-1:0]   load_val;
  logic [DATA_W-1:0]   merged;
  logic                misalign;
  logic                range_err;
  logic                req_err;

  assign idle = (state_q == ST_IDLE);

  // The lane unit checks alignment of the incoming request while idle and
  // processes the latched access afterwards.
  assign lane_f3   = idle ? bus.req_funct3 : f3_q;
  assign lane_addr = idle ? bus.req_addr[1:0] : addr_q[1:0];

  dmem_lane u_lane (
    .word_i     (bus.mem_re_data),
    .funct3_i   (lane_f3),
    .addr_i     (lane_addr),
    .sdata_i    (wr_q),
    .load_o     (load_val),
    .merged_o   (merged),
    .misalign_o (misalign)
  );

`ifdef DMEM_CTRL_RANGE_CHECK_EN
  assign range_err = |bus.req_addr[31:ADDR_W+2];
`else
  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.req_addr[31:ADDR_W+2];
  assign range_err      = 1'b0;
`endif

  assign req_err = misalign || range_err || f3_illegal(bus.req_funct3, bus.req_we);

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
    state_d      = state_q;
    addr_d       = addr_q;
    f3_d         = f3_q;
    we_d         = we_q;
    wr_d         = wr_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          addr_d = bus.req_addr[ADDR_W+1:0];
          f3_d   = bus.req_funct3;
          we_d   = bus.req_we;
          wr_d   = bus.req_wdata;
          if (req_err) begin
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
            state_d      = ST_RESP;
          end else if (bus.req_we && (bus.req_funct3 == F3_W)) begin
            state_d = ST_WRITE;
          end else begin
            state_d = ST_READ;
          end
        end
      end
      ST_READ:  state_d = ST_RDATA;
      ST_RDATA: begin
        if (we_q) begin
          wr_d    = merged;
          state_d = ST_WRITE;
        end else begin
          resp_rdata_d = load_val;
          resp_valid_d = 1'b1;
          state_d      = ST_RESP;
        end
      end
      ST_WRITE: begin
        resp_valid_d = 1'b1;
        resp_rdata_d = '0;
        state_d      = ST_RESP;
      end
      ST_RESP: begin
        if (bus.resp_ready) begin
          resp_valid_d = 1'b0;
          resp_rdata_d = '0;
          resp_err_d   = 1'b0;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: only controller state is reset; the memory array has none, so a
  // write already on the port when reset is sampled still commits.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      f3_q         <= '0;
      we_q         <= 1'b0;
      wr_q         <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      f3_q         <= f3_d;
      we_q         <= we_d;
      wr_q         <= wr_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign bus.req_ready     = idle;
  assign bus.resp_valid    = resp_valid_q;
  assign bus.resp_rdata    = resp_rdata_q;
  assign bus.resp_err      = resp_err_q;
  assign bus.mem_rw_enable = (state_q == ST_WRITE);
  assign bus.mem_address   = idle ? '0 : addr_q[ADDR_W+1:2];
  assign bus.mem_wr_data   = (state_q == ST_WRITE) ? wr_q : '0;

endmodule
